stopwatch_controller: RTL

- Sequences a four-digit MM:SS stopwatch: prescales the board clock into a 1-per-TICK_DIV count tick and runs a start/pause/clear state machine.
- Steps cascaded BCD digit counters (ones 0-9, tens 0-5) with carry.
- Time-multiplexes the single shared active-low 7-segment bus across four digit anodes.
- Sits between the push-button inputs and the display pins, replacing the per-digit free-running counters.

---
 rtl/stopwatch_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch sequencer: start/pause/clear FSM, prescaled BCD digit cascade,
// and a time-multiplexed active-low 7-segment scan across four anodes.
module stopwatch_controller #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        startStop,
    input  logic        clear,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        running,
    output logic        rollover,
    output logic [1:0]  state_dbg,
    output logic [15:0] digits_dbg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic          ss_q;
    logic          clr_q;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic [3:0]    s_o;
    logic [3:0]    s_t;
    logic [3:0]    m_o;
    logic [3:0]    m_t;
    logic [3:0]    cur_digit;

    logic start_cmd;
    logic clear_cmd;
    logic tick;
    logic advance;

    assign start_cmd = startStop & ~ss_q;
    assign clear_cmd = clear & ~clr_q;
    assign tick      = (state == RUN) && (tick_cnt == TICK_LAST);
    // A tick coinciding with a pause or clear command is not counted.
    assign advance   = tick & ~start_cmd & ~clear_cmd;

    assign state_dbg  = state;
    assign digits_dbg = {m_t, m_o, s_t, s_o};

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            running <= 1'b0;
            ss_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            ss_q  <= startStop;
            clr_q <= clear;
            if (clear_cmd) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (start_cmd) begin
                case (state)
                    IDLE, PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The prescaler only moves on edges where RUN is kept, so a pause freezes
    // the partial period and a suppressed tick fires right after resume.
    always_ff @(posedge clock) begin
        if (!resetn || clear_cmd) begin
            tick_cnt <= '0;
        end else if (state == RUN && !start_cmd) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || clear_cmd) begin
            s_o      <= 4'd0;
            s_t      <= 4'd0;
            m_o      <= 4'd0;
            m_t      <= 4'd0;
            rollover <= 1'b0;
        end else begin
            rollover <= 1'b0;
            if (advance) begin
                if (s_o >= 4'd9) begin
                    s_o <= 4'd0;
                    if (s_t >= 4'd5) begin
                        s_t <= 4'd0;
                        if (m_o >= 4'd9) begin
                            m_o <= 4'd0;
                            if (m_t >= 4'd5) begin
                                m_t      <= 4'd0;
                                rollover <= 1'b1;
                            end else begin
                                m_t <= m_t + 4'd1;
                            end
                        end else begin
                            m_o <= m_o + 4'd1;
                        end
                    end else begin
                        s_t <= s_t + 4'd1;
                    end
                end else begin
                    s_o <= s_o + 4'd1;
                end
            end
        end
    end

    always_comb begin
        cur_digit = s_o;
        case (scan_idx)
            2'd0: cur_digit = s_o;
            2'd1: cur_digit = s_t;
            2'd2: cur_digit = m_o;
            2'd3: cur_digit = m_t;
            default: cur_digit = s_o;
        endcase
    end

    // Scan keeps running through clear; only reset restarts it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            an       <= 4'b1110;
            seg      <= 7'b0000001;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_code(cur_digit);
        end
    end

endmodule
